// File: rtl/bus_stall_pkg.sv
// Shared types and default sizing for the bus stall controller.
package bus_stall_pkg;

   localparam int BSC_CMD_W_DEF  = 4;
   localparam int BSC_NUM_CH_DEF = 2;
   localparam int BSC_CNT_W_DEF  = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_STALL  = 2'd2
   } state_e;

endpackage

// File: rtl/bus_stall_ctrl_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching from the channel after the
// last one advanced on; channel 0 has first priority after reset.
module rr_arbiter #(
   parameter int NUM_CH = 2
) (
   input  logic              clk,
   input  logic              rst_,
   input  logic [NUM_CH-1:0] req,
   input  logic              advance,
   output logic [NUM_CH-1:0] gnt
);

   localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic [IDX_W-1:0] last_q, last_d;
   logic             found;
   int unsigned      idx;

   // Pick the first requesting channel after last_q, wrapping around.
   always_comb begin
      gnt    = '0;
      found  = 1'b0;
      last_d = last_q;
      idx    = 0;
      for (int unsigned k = 1; k <= 32'(NUM_CH); k++) begin
         idx = (32'(last_q) + k) % 32'(NUM_CH);
         for (int unsigned i = 0; i < 32'(NUM_CH); i++) begin
            if (!found && (i == idx) && req[i]) begin
               gnt[i] = 1'b1;
               found  = 1'b1;
               last_d = IDX_W'(i);
            end
         end
      end
   end

   // Pointer to the last granted channel; reset points at the top channel so
   // the search starts at channel 0.
   always_ff @(posedge clk) begin
      if (rst_) begin
         last_q <= IDX_W'(NUM_CH - 1);
      end else if (advance && found) begin
         last_q <= last_d;
      end
   end

endmodule

// File: rtl/bus_stall_ctrl.sv
// Bus stall controller: grants one requesting channel round-robin, holds its
// command while busy, and flags a stall after stall_limit active cycles.
// Optional macro BUS_STALL_CTRL_PERF_EN adds a saturating stall_events count.
module bus_stall_ctrl
   import bus_stall_pkg::*;
#(
   parameter int CMD_W  = BSC_CMD_W_DEF,
   parameter int NUM_CH = BSC_NUM_CH_DEF,
   parameter int CNT_W  = BSC_CNT_W_DEF
) (
   input  logic                    clk,
   input  logic                    rst_,
   input  logic [NUM_CH-1:0]       en,
   input  logic [NUM_CH*CMD_W-1:0] cmd,
   input  logic                    done,
   input  logic [CNT_W-1:0]        stall_limit,
   output logic [NUM_CH-1:0]       grant,
   output logic [CMD_W-1:0]        cmd_out,
   output logic                    busy,
`ifdef BUS_STALL_CTRL_PERF_EN
   output logic [15:0]             stall_events,
`endif
   output logic                    stall
);

   state_e            state_q, state_d;
   logic [NUM_CH-1:0] grant_q, grant_d;
   logic [CMD_W-1:0]  cmd_out_q, cmd_out_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [NUM_CH-1:0] arb_gnt;
   logic              arb_adv;
   logic              limit_hit;

   assign arb_adv   = (state_q == ST_IDLE) && (|en);
   // >= rather than == keeps cnt from running past a limit lowered mid-command.
   assign limit_hit = (cnt_q >= stall_limit);

   rr_arbiter #(
      .NUM_CH(NUM_CH)
   ) u_arb (
      .clk    (clk),
      .rst_   (rst_),
      .req    (en),
      .advance(arb_adv),
      .gnt    (arb_gnt)
   );

   // Next-state logic: grant in IDLE, count in ACTIVE, done overrides stall.
   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      cmd_out_d = cmd_out_q;
      cnt_d     = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (|en) begin
               state_d = ST_ACTIVE;
               grant_d = arb_gnt;
               cnt_d   = '0;
               for (int unsigned i = 0; i < 32'(NUM_CH); i++) begin
                  if (arb_gnt[i]) cmd_out_d = cmd[i*CMD_W +: CMD_W];
               end
            end
         end
         ST_ACTIVE: begin
            if (done) begin
               state_d = ST_IDLE;
               grant_d = '0;
               cnt_d   = '0;
            end else if (limit_hit) begin
               state_d = ST_STALL;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_STALL: begin
            if (done) begin
               state_d = ST_IDLE;
               grant_d = '0;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            grant_d = '0;
            cnt_d   = '0;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (rst_) begin
         state_q   <= ST_IDLE;
         grant_q   <= '0;
         cmd_out_q <= '0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         cmd_out_q <= cmd_out_d;
         cnt_q     <= cnt_d;
      end
   end

   assign grant   = grant_q;
   assign cmd_out = cmd_out_q;
   assign busy    = (state_q != ST_IDLE);
   assign stall   = (state_q == ST_STALL);

`ifdef BUS_STALL_CTRL_PERF_EN
   logic [15:0] stall_events_q;

   // Count ACTIVE->STALL transitions, saturating at all-ones.
   always_ff @(posedge clk) begin
      if (rst_) begin
         stall_events_q <= '0;
      end else if ((state_q == ST_ACTIVE) && !done && limit_hit &&
                   (stall_events_q != '1)) begin
         stall_events_q <= stall_events_q + 16'd1;
      end
   end

   assign stall_events = stall_events_q;
`endif

endmodule

// File: tb/tb_bus_stall_ctrl.sv
// Self-checking bench for bus_stall_ctrl: directed scenarios followed by
// randomized traffic against a cycle-level behavioural model.
module tb_bus_stall_ctrl;

   localparam int CMD_W  = 4;
   localparam int NUM_CH = 2;
   localparam int CNT_W  = 4;

   logic                    clk;
   logic                    rst_;
   logic [NUM_CH-1:0]       en;
   logic [NUM_CH*CMD_W-1:0] cmd;
   logic                    done;
   logic [CNT_W-1:0]        stall_limit;
   logic [NUM_CH-1:0]       grant;
   logic [CMD_W-1:0]        cmd_out;
   logic                    busy;
   logic                    stall;
`ifdef BUS_STALL_CTRL_PERF_EN
   logic [15:0]             stall_events;
`endif

   int tests_run    = 0;
   int tests_failed = 0;

   // Model: a command is "busy" from its grant until done; it is stalled once
   // more than stall_limit edges have passed since the grant.
   bit                m_busy;
   bit                m_stall;
   logic [NUM_CH-1:0] m_grant;
   logic [CMD_W-1:0]  m_cmd;
   int                m_last;
   int                m_age;
   int                m_events;

   bus_stall_ctrl #(
      .CMD_W (CMD_W),
      .NUM_CH(NUM_CH),
      .CNT_W (CNT_W)
   ) dut (
      .clk         (clk),
      .rst_        (rst_),
      .en          (en),
      .cmd         (cmd),
      .done        (done),
      .stall_limit (stall_limit),
      .grant       (grant),
      .cmd_out     (cmd_out),
      .busy        (busy),
`ifdef BUS_STALL_CTRL_PERF_EN
      .stall_events(stall_events),
`endif
      .stall       (stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_step(input logic r, input logic [NUM_CH-1:0] e,
                             input logic [NUM_CH*CMD_W-1:0] c, input logic d,
                             input logic [CNT_W-1:0] lim);
      bit found;
      int ch;
      if (r) begin
         m_busy   = 0;
         m_stall  = 0;
         m_grant  = '0;
         m_cmd    = '0;
         m_last   = NUM_CH - 1;
         m_age    = 0;
         m_events = 0;
      end else if (!m_busy) begin
         found = 0;
         for (int k = 1; k <= NUM_CH; k++) begin
            ch = (m_last + k) % NUM_CH;
            if (!found && e[ch]) begin
               found   = 1;
               m_last  = ch;
               m_busy  = 1;
               m_stall = 0;
               m_age   = 0;
               m_grant = NUM_CH'(1) << ch;
               m_cmd   = c[ch*CMD_W +: CMD_W];
            end
         end
      end else if (d) begin
         m_busy  = 0;
         m_stall = 0;
         m_grant = '0;
         m_age   = 0;
      end else begin
         m_age++;
         if (!m_stall && (m_age >= int'(lim) + 1)) begin
            m_stall = 1;
            if (m_events < 65535) m_events++;
         end
      end
   endtask

   // Apply inputs for one edge, advance the model, then compare at the next negedge.
   task automatic cycle(input logic r, input logic [NUM_CH-1:0] e,
                        input logic [NUM_CH*CMD_W-1:0] c, input logic d,
                        input logic [CNT_W-1:0] lim);
      rst_        = r;
      en          = e;
      cmd         = c;
      done        = d;
      stall_limit = lim;
      model_step(r, e, c, d, lim);
      @(negedge clk);
      check("grant",   32'(grant),   32'(m_grant));
      check("cmd_out", 32'(cmd_out), 32'(m_cmd));
      check("busy",    32'(busy),    32'(m_busy));
      check("stall",   32'(stall),   32'(m_stall));
`ifdef BUS_STALL_CTRL_PERF_EN
      check("stall_events", 32'(stall_events), 32'(m_events));
`endif
   endtask

   logic [CNT_W-1:0] rnd_lim;

   initial begin
      rst_ = 1'b1; en = '0; cmd = '0; done = 1'b0; stall_limit = '0;
      #2;

      // Reset state
      cycle(1, 2'b00, 8'h00, 0, 4'd3);
      cycle(1, 2'b00, 8'h00, 0, 4'd3);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_grant", 32'(grant), 32'd0);

      // First grant, then stall after limit+1 active cycles
      cycle(0, 2'b01, 8'h0A, 0, 4'd3);
      check("first_grant", 32'(grant), 32'h1);
      check("first_cmd", 32'(cmd_out), 32'hA);
      check("first_busy", 32'(busy), 32'd1);
      check("first_stall", 32'(stall), 32'd0);
      for (int i = 0; i < 3; i++) begin
         cycle(0, 2'b00, 8'h00, 0, 4'd3);
         check("pre_stall", 32'(stall), 32'd0);
      end
      cycle(0, 2'b00, 8'h00, 0, 4'd3);
      check("stall_rise", 32'(stall), 32'd1);
      cycle(0, 2'b00, 8'h00, 1, 4'd3);
      check("done_busy", 32'(busy), 32'd0);
      check("done_stall", 32'(stall), 32'd0);
      check("hold_cmd", 32'(cmd_out), 32'hA);

      // Round-robin alternation with both channels requesting
      cycle(1, 2'b00, 8'h00, 0, 4'd5);
      cycle(0, 2'b11, 8'h5C, 0, 4'd5);
      check("rr0", 32'(grant), 32'h1);
      check("rr0_cmd", 32'(cmd_out), 32'hC);
      cycle(0, 2'b11, 8'h5C, 1, 4'd5);
      check("rr_idle", 32'(busy), 32'd0);
      cycle(0, 2'b11, 8'h5C, 0, 4'd5);
      check("rr1", 32'(grant), 32'h2);
      check("rr1_cmd", 32'(cmd_out), 32'h5);
      cycle(0, 2'b11, 8'h5C, 1, 4'd5);
      cycle(0, 2'b11, 8'h5C, 0, 4'd5);
      check("rr2", 32'(grant), 32'h1);
      cycle(0, 2'b00, 8'h00, 1, 4'd5);

      // done in the cycle the count reaches the limit wins over stall
      cycle(0, 2'b10, 8'h70, 0, 4'd2);
      cycle(0, 2'b00, 8'h00, 0, 4'd2);
      cycle(0, 2'b00, 8'h00, 0, 4'd2);
      check("race_nostall", 32'(stall), 32'd0);
      cycle(0, 2'b00, 8'h00, 1, 4'd2);
      check("race_idle", 32'(busy), 32'd0);
      check("race_stall", 32'(stall), 32'd0);

      // Reset mid-STALL, then channel 0 gets priority
      cycle(0, 2'b10, 8'h90, 0, 4'd0);
      cycle(0, 2'b00, 8'h00, 0, 4'd0);
      check("lim0_stall", 32'(stall), 32'd1);
      cycle(1, 2'b11, 8'hFF, 0, 4'd0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_cmd", 32'(cmd_out), 32'd0);
      cycle(0, 2'b11, 8'h21, 0, 4'd0);
      check("after_rst_grant", 32'(grant), 32'h1);
      cycle(0, 2'b00, 8'h00, 1, 4'd0);

`ifdef BUS_STALL_CTRL_PERF_EN
      cycle(1, 2'b00, 8'h00, 0, 4'd0);
      for (int n = 0; n < 5; n++) begin
         cycle(0, 2'b01, 8'h03, 0, 4'd0);
         cycle(0, 2'b00, 8'h00, 0, 4'd0);
         cycle(0, 2'b00, 8'h00, 1, 4'd0);
      end
      check("perf_five", 32'(stall_events), 32'd5);
      cycle(1, 2'b00, 8'h00, 0, 4'd0);
      check("perf_rst", 32'(stall_events), 32'd0);
`endif

      // Randomized traffic; the limit only changes while no command is held
      rnd_lim = 4'd2;
      for (int n = 0; n < 3000; n++) begin
         if (!m_busy) rnd_lim = CNT_W'($urandom_range(0, 6));
         cycle(($urandom_range(0, 79) == 0), NUM_CH'($urandom),
               (NUM_CH*CMD_W)'($urandom), ($urandom_range(0, 5) == 0), rnd_lim);
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/bus_stall_ctrl.md
BUS_STALL_CTRL -- requirements
Module: bus_stall_ctrl

Interface
- REQ-001: Parameter CMD_W, default 4, SHALL set the command width in bits.
- REQ-002: Parameter NUM_CH, default 2, SHALL set the number of requesting channels (range 1..8).
- REQ-003: Parameter CNT_W, default 4, SHALL set the stall counter width in bits.
- REQ-004: clk  input  1  SHALL be the single clock; all logic SHALL update on its rising edge.
- REQ-005: rst_  input  1  SHALL be the reset, synchronous and active-high.
- REQ-006: en  input  NUM_CH  SHALL carry one request bit per channel.
- REQ-007: cmd  input  NUM_CH*CMD_W  SHALL carry the packed per-channel commands, channel i at bits [i*CMD_W +: CMD_W].
- REQ-008: done  input  1  SHALL signal completion of the active command.
- REQ-009: stall_limit  input  CNT_W  SHALL set the number of active cycles before stall asserts.
- REQ-010: grant  output  NUM_CH  SHALL be a one-hot mask of the granted channel, held while busy.
- REQ-011: cmd_out  output  CMD_W  SHALL hold the captured command of the granted channel.
- REQ-012: busy  output  1  SHALL be high in ACTIVE and STALL.
- REQ-013: stall  output  1  SHALL be high only in STALL.

Function
- REQ-014: FSM states SHALL be IDLE, ACTIVE and STALL.
- REQ-015: In IDLE with any en bit high, the block SHALL grant one channel round-robin, starting after the last granted channel, capture its cmd into cmd_out, clear cnt, and enter ACTIVE on the next edge.
- REQ-016: en SHALL be ignored outside IDLE; there SHALL be no queuing.
- REQ-017: In ACTIVE, cnt SHALL increment by 1 each cycle; when cnt equals stall_limit, the block SHALL enter STALL on the next edge.
- REQ-018: stall_limit = 0 SHALL cause entry to STALL one cycle after ACTIVE is entered.
- REQ-019: cnt SHALL NOT wrap; it SHALL stop at stall_limit.
- REQ-020: done high in ACTIVE or STALL SHALL return the FSM to IDLE on the next edge and clear grant, busy and stall.
- REQ-021: done SHALL take priority over the stall transition in the same cycle.
- REQ-022: done in IDLE SHALL be ignored.
- REQ-023: A return to IDLE SHALL allow a new grant no earlier than the following cycle (one IDLE cycle minimum).
- REQ-024: cmd_out SHALL retain its last value in IDLE.

Reset
- REQ-025: While rst_ is high at a clock edge, state SHALL become IDLE; grant, cmd_out, busy, stall and cnt SHALL become 0; and the round-robin pointer SHALL select channel 0 first.
- REQ-026: Reset asserted during ACTIVE or STALL SHALL abort the command with no completion.

Configuration
- REQ-027: Macro BUS_STALL_CTRL_PERF_EN, when defined, SHALL add output stall_events [15:0], which increments on each ACTIVE->STALL transition, saturates at 16'hFFFF, and resets to 0.
- REQ-028: Without BUS_STALL_CTRL_PERF_EN, the port and counter SHALL be absent and all other behaviour SHALL be identical.

Structure
- REQ-029: Package bus_stall_pkg SHALL hold the FSM state enum and the default CMD_W, NUM_CH and CNT_W constants.
- REQ-030: Round-robin selection SHALL be a sub-module rr_arbiter (inputs: req, advance; output: one-hot gnt).

Verification
- REQ-031: Reset, then en=2'b01, cmd[3:0]=4'hA -> after one edge: grant=01, cmd_out=A, busy=1, stall=0.
- REQ-032: stall_limit=3, no done -> stall rises exactly 4 cycles after busy rises; done then clears stall/busy next edge.
- REQ-033: en=2'b11 held across three commands -> grants alternate 01, 10, 01.
- REQ-034: done in the same cycle cnt reaches stall_limit -> IDLE, stall never asserts.
- REQ-035: rst_ pulsed mid-STALL -> all outputs 0 next edge; next en=2'b11 grants channel 0.
- REQ-036: With BUS_STALL_CTRL_PERF_EN: 5 stalled commands -> stall_events=5; reset -> 0.
